// File: rtl/count_watch.sv
// count_watch: monitors a counter sample stream, raises a hysteresis alarm
// interrupt with level/ack handshake, and keeps wrap and peak statistics.
module count_watch #(
    parameter int CW     = 6,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     count_in,
    input  logic              count_vld,
    input  logic [CW-1:0]     thr_hi,
    input  logic [CW-1:0]     thr_lo,
    input  logic              irq_ack,
    output logic              irq,
    output logic [1:0]        state,
    output logic              above,
    output logic [CW-1:0]     peak,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [CW-1:0]     last_sample
);

    typedef enum logic [1:0] {
        ST_BELOW = 2'd0,
        ST_ALERT = 2'd1,
        ST_ABOVE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    function automatic logic [CW-1:0] umax(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t            state_q, state_d;
    logic              irq_q, irq_d;
    logic              above_q, above_d;
    logic [CW-1:0]     peak_q, peak_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [CW-1:0]     last_q, last_d;
    logic              first_q, first_d;
    logic [CW-1:0]     lo_e_s;
    logic              ack_acc_s;

    // A release threshold above the alarm threshold is clamped down to it.
    assign lo_e_s    = (thr_lo < thr_hi) ? thr_lo : thr_hi;
    assign ack_acc_s = irq_ack && (state_q == ST_ALERT);

    // Next-state and statistics computation.
    always_comb begin
        state_d = state_q;
        above_d = above_q;
        last_d  = last_q;
        first_d = first_q;
        wrap_d  = wrap_q;
        peak_d  = peak_q;

        if (count_vld) begin
            last_d  = count_in;
            first_d = 1'b1;
            above_d = (count_in >= lo_e_s);
            if (first_q && (count_in < last_q) && (wrap_q != WRAP_MAX)) begin
                wrap_d = wrap_q + {{(WRAP_W-1){1'b0}}, 1'b1};
            end else begin
                wrap_d = wrap_q;
            end
        end else begin
            last_d = last_q;
        end

        if (ack_acc_s) begin
            peak_d = count_vld ? count_in : {CW{1'b0}};
        end else if (count_vld) begin
            peak_d = umax(peak_q, count_in);
        end else begin
            peak_d = peak_q;
        end

        case (state_q)
            ST_BELOW: begin
                if (count_vld && (count_in >= thr_hi)) begin
                    state_d = ST_ALERT;
                end else begin
                    state_d = ST_BELOW;
                end
            end
            ST_ALERT: begin
                if (irq_ack) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ALERT;
                end
            end
            // HOLD uses the registered above flag, i.e. the sample seen before this cycle.
            ST_HOLD: begin
                if (above_q) begin
                    state_d = ST_ABOVE;
                end else begin
                    state_d = ST_BELOW;
                end
            end
            ST_ABOVE: begin
                if (count_vld && (count_in < lo_e_s)) begin
                    state_d = ST_BELOW;
                end else begin
                    state_d = ST_ABOVE;
                end
            end
            default: state_d = ST_BELOW;
        endcase

        irq_d = (state_d == ST_ALERT);
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BELOW;
            irq_q   <= 1'b0;
            above_q <= 1'b0;
            peak_q  <= {CW{1'b0}};
            wrap_q  <= {WRAP_W{1'b0}};
            last_q  <= {CW{1'b0}};
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            above_q <= above_d;
            peak_q  <= peak_d;
            wrap_q  <= wrap_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    assign irq         = irq_q;
    assign state       = state_q;
    assign above       = above_q;
    assign peak        = peak_q;
    assign wrap_cnt    = wrap_q;
    assign last_sample = last_q;

endmodule
